// File: rtl/approx_mul_eval_ctrl_if.sv
// Bundle of signals between the approximate-multiplier evaluation controller and its
// environment (run requester plus the external multiplier under test).
//   start, num_samples   : run request and sample count
//   mul_a, mul_b, mul_p  : operands to, and product from, the multiplier under test
//   busy, done           : run status
//   sample_cnt, err_count, sum_abs_ed, max_ed : accumulated statistics
// Modports: master = environment side, slave = controller side.
interface approx_mul_eval_ctrl_if;
    logic        start;
    logic [23:0] num_samples;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        busy;
    logic        done;
    logic [23:0] sample_cnt;
    logic [23:0] err_count;
    logic [39:0] sum_abs_ed;
    logic [15:0] max_ed;

    modport master (
        output start, num_samples, mul_p,
        input  mul_a, mul_b, busy, done, sample_cnt, err_count, sum_abs_ed, max_ed
    );

    modport slave (
        input  start, num_samples, mul_p,
        output mul_a, mul_b, busy, done, sample_cnt, err_count, sum_abs_ed, max_ed
    );
endinterface

// File: rtl/approx_mul_eval_ctrl.sv
// Error-characterisation controller for an external 8x8 approximate multiplier.
// Drives LFSR-generated operand pairs, waits SETTLE_CYCLES, samples the product and
// accumulates error count, sum of absolute error distance and maximum error distance.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : approx_mul_eval_ctrl_if.slave (start/num_samples in, operands out,
//           product in, status and statistics out)
module approx_mul_eval_ctrl #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    approx_mul_eval_ctrl_if.slave bus
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_lfsr;
    logic [23:0] r_num;
    logic [7:0]  r_settle;
    logic [7:0]  r_mul_a;
    logic [7:0]  r_mul_b;
    logic [23:0] r_sample_cnt;
    logic [23:0] r_err_count;
    logic [39:0] r_sum_abs_ed;
    logic [15:0] r_max_ed;

    logic [15:0] w_exact;
    logic [15:0] w_ed;
    logic        w_mismatch;
    logic [15:0] w_lfsr_nxt;
    logic [23:0] w_cnt_nxt;

    assign w_exact    = {8'h00, r_mul_a} * {8'h00, r_mul_b};
    assign w_mismatch = (bus.mul_p != w_exact);
    assign w_ed       = (w_exact >= bus.mul_p) ? (w_exact - bus.mul_p) : (bus.mul_p - w_exact);
    // Galois LFSR, right shift, taps 16'hB400.
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    assign w_cnt_nxt  = r_sample_cnt + 24'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= SEED_EFF;
            r_num        <= 24'd0;
            r_settle     <= 8'd0;
            r_mul_a      <= 8'd0;
            r_mul_b      <= 8'd0;
            r_sample_cnt <= 24'd0;
            r_err_count  <= 24'd0;
            r_sum_abs_ed <= 40'd0;
            r_max_ed     <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_num        <= bus.num_samples;
                        r_sample_cnt <= 24'd0;
                        r_err_count  <= 24'd0;
                        r_sum_abs_ed <= 40'd0;
                        r_max_ed     <= 16'd0;
                        r_lfsr       <= SEED_EFF;
                        r_mul_a      <= SEED_EFF[15:8];
                        r_mul_b      <= SEED_EFF[7:0];
                        r_settle     <= SETTLE_LD;
                        r_state      <= (bus.num_samples == 24'd0) ? S_DONE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Counter starts at SETTLE_CYCLES; leaving on 1 gives exactly that many cycles.
                    r_settle <= r_settle - 8'd1;
                    if (r_settle == 8'd1) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_err_count  <= r_err_count + {23'd0, w_mismatch};
                    r_sum_abs_ed <= r_sum_abs_ed + {24'd0, w_ed};
                    r_max_ed     <= (w_ed > r_max_ed) ? w_ed : r_max_ed;
                    r_sample_cnt <= w_cnt_nxt;
                    r_lfsr       <= w_lfsr_nxt;
                    r_mul_a      <= w_lfsr_nxt[15:8];
                    r_mul_b      <= w_lfsr_nxt[7:0];
                    r_settle     <= SETTLE_LD;
                    r_state      <= (w_cnt_nxt == r_num) ? S_DONE : S_SETTLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.busy       = (r_state == S_SETTLE) || (r_state == S_ACCUM);
    assign bus.done       = (r_state == S_DONE);
    assign bus.sample_cnt = r_sample_cnt;
    assign bus.err_count  = r_err_count;
    assign bus.sum_abs_ed = r_sum_abs_ed;
    assign bus.max_ed     = r_max_ed;

endmodule

// File: tb/tb_approx_mul_eval_ctrl.sv
// Self-checking bench for approx_mul_eval_ctrl: a behavioural model derives every output
// from the cycle count since start acceptance and is compared on every falling edge.
module tb_approx_mul_eval_ctrl;

    localparam int unsigned S    = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned mode = 0;
    int          total = 0;
    int          bad = 0;

    approx_mul_eval_ctrl_if bus ();

    approx_mul_eval_ctrl #(
        .SEED          (SEED),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Multiplier models: 0 exact, 1 stuck-at-zero, 2 LSB flip, 3 truncated, 4 xor-corrupted.
    function automatic logic [15:0] mulp(input int unsigned md, input logic [7:0] a,
                                         input logic [7:0] b);
        logic [15:0] ex;
        ex = {8'h00, a} * {8'h00, b};
        case (md)
            0:       return ex;
            1:       return 16'h0000;
            2:       return ex ^ 16'h0001;
            3:       return ex & 16'hFFC0;
            default: return ex ^ {8'h00, a};
        endcase
    endfunction

    assign bus.mul_p = mulp(mode, bus.mul_a, bus.mul_b);

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Statistics after c samples of a run, plus the LFSR state driving the operands.
    task automatic model_stats(input int unsigned md, input int unsigned c,
                               output logic [15:0] l, output logic [23:0] e,
                               output logic [39:0] s, output logic [15:0] m);
        logic [15:0] ex;
        logic [15:0] p;
        logic [15:0] d;
        l = SEED; e = 0; s = 0; m = 0;
        for (int unsigned k = 0; k < c; k++) begin
            ex = {8'h00, l[15:8]} * {8'h00, l[7:0]};
            p  = mulp(md, l[15:8], l[7:0]);
            d  = (ex > p) ? ex - p : p - ex;
            if (d != 0) e = e + 1;
            s = s + {24'd0, d};
            if (d > m) m = d;
            l = lfsr_step(l);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: phase 0 = after reset, phase 1 = m_n edges since the last accepted start.
    int          m_phase = 0;
    int unsigned m_n = 0;
    int unsigned m_N = 0;
    int unsigned m_mode = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
        end else if (bus.start && (m_phase == 0 || m_n >= m_N * (S + 1))) begin
            m_phase <= 1;
            m_n     <= 0;
            m_N     <= bus.num_samples;
            m_mode  <= mode;
        end else if (m_phase == 1 && m_n < 32'hFFFF_0000) begin
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin : compare
        int unsigned c;
        logic [15:0] l;
        logic [23:0] e;
        logic [39:0] s;
        logic [15:0] m;
        logic        busy_e;
        if (rst_n) begin
            if (m_phase == 0) begin
                l = 16'h0; e = 0; s = 0; m = 0; c = 0; busy_e = 1'b0;
                chk("idle_done", bus.done, 0);
            end else begin
                c = m_n / (S + 1);
                if (c > m_N) c = m_N;
                model_stats(m_mode, c, l, e, s, m);
                busy_e = (m_n < m_N * (S + 1));
                chk("done", bus.done, !busy_e);
            end
            chk("busy", bus.busy, busy_e);
            chk("mul_a", bus.mul_a, l[15:8]);
            chk("mul_b", bus.mul_b, l[7:0]);
            chk("sample_cnt", bus.sample_cnt, c);
            chk("err_count", bus.err_count, e);
            chk("sum_abs_ed", bus.sum_abs_ed, s);
            chk("max_ed", bus.max_ed, m);
        end
    end

    // Returns on the falling edge after the accepting edge.
    task automatic start_run(input int unsigned md, input int unsigned n);
        @(negedge clk);
        mode = md;
        bus.num_samples = n[23:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.num_samples = 24'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit pulses, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < budget && !bus.done; i++) begin
            if (bus.busy) busy_cycles++;
            bus.start = pulses && ($urandom_range(0, 7) == 0);
            if (pulses) bus.num_samples = 24'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("wait_done", bus.done, 1);
    endtask

    initial begin
        int bc;
        int unsigned n;
        int unsigned md;
        bus.start = 1'b0;
        bus.num_samples = 24'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        #2 rst_n = 1'b1;

        // Exact multiplier, 100 samples: 300 busy cycles, no error.
        start_run(0, 100);
        wait_done(400, 1'b0, bc);
        chk("ideal_busy_cycles", bc, 300);
        chk("ideal_sample_cnt", bus.sample_cnt, 100);
        chk("ideal_err", bus.err_count, 0);
        chk("ideal_sum", bus.sum_abs_ed, 0);
        chk("ideal_max", bus.max_ed, 0);

        // Stuck-at-zero, one sample: AC*E1 = 38700. Next state: ACE1>>1 = 5670, lsb set -> E270.
        start_run(1, 1);
        chk("sz_mul_a", bus.mul_a, 8'hAC);
        chk("sz_mul_b", bus.mul_b, 8'hE1);
        wait_done(20, 1'b0, bc);
        chk("sz_err", bus.err_count, 1);
        chk("sz_sum", bus.sum_abs_ed, 38700);
        chk("sz_max", bus.max_ed, 38700);
        chk("sz_next_a", bus.mul_a, 8'hE2);
        chk("sz_next_b", bus.mul_b, 8'h70);

        // LSB flip, 50 samples.
        start_run(2, 50);
        wait_done(200, 1'b0, bc);
        chk("lsb_err", bus.err_count, 50);
        chk("lsb_sum", bus.sum_abs_ed, 50);
        chk("lsb_max", bus.max_ed, 1);

        // Zero samples: done on the first edge, never busy.
        start_run(0, 0);
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        wait_done(5, 1'b0, bc);
        chk("zero_busy_cycles", bc, 0);

        // Start pulses while busy are ignored.
        start_run(3, 20);
        wait_done(200, 1'b1, bc);
        chk("pulse_busy_cycles", bc, 60);
        chk("pulse_sample_cnt", bus.sample_cnt, 20);

        // Reset in the middle of sample 5, then a clean rerun.
        start_run(4, 20);
        for (int i = 0; i < 100 && bus.sample_cnt != 24'd5; i++) @(negedge clk);
        chk("mid_reached", bus.sample_cnt, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_cnt", bus.sample_cnt, 0);
        chk("mid_rst_err", bus.err_count, 0);
        chk("mid_rst_sum", bus.sum_abs_ed, 0);
        chk("mid_rst_max", bus.max_ed, 0);
        chk("mid_rst_a", bus.mul_a, 0);
        chk("mid_rst_b", bus.mul_b, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        start_run(4, 20);
        chk("rerun_mul_a", bus.mul_a, 8'hAC);
        wait_done(100, 1'b0, bc);
        chk("rerun_busy_cycles", bc, 60);
        chk("rerun_sample_cnt", bus.sample_cnt, 20);

        // Randomised runs.
        repeat (12) begin
            md = $urandom_range(0, 4);
            n  = $urandom_range(0, 40);
            start_run(md, n);
            wait_done(int'(n * (S + 1)) + 10, 1'($urandom_range(0, 1)), bc);
            chk("rand_busy_cycles", bc, n * (S + 1));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
